// File: rtl/pcie_phy_pkg.sv
// rtl/pcie_phy_pkg.sv - shared PCIe PHY symbol, training-set and TS ordered-set config types
package pcie_phy_pkg;

    localparam int TSOS_SYMS = 16;

    typedef enum logic [7:0] {
        K28_5_COM = 8'hBC,
        K23_7_PAD = 8'hF7,
        K28_0_SKP = 8'h1C,
        K28_1_FTS = 8'h3C,
        K28_3_IDL = 8'h7C
    } phy_special_k_e;

    typedef enum logic [7:0] {
        TS1 = 8'h4A,
        TS2 = 8'h45
    } train_seq_e;

    typedef enum logic [7:0] {
        RATE_GEN1 = 8'h02,
        RATE_GEN2 = 8'h06,
        RATE_GEN3 = 8'h0E
    } rate_id_e;

    typedef struct packed {
        logic [3:0] rsvd;
        logic       scramble_dis;
        logic       loopback;
        logic       disable_link;
        logic       hot_reset;
    } training_ctrl_t;

    // Configuration captured at burst start; held for the whole burst
    typedef struct packed {
        train_seq_e     ts_type;
        logic [7:0]     link_num;
        logic           link_pad;
        logic           lane_pad;
        logic           lane_rev;
        logic [7:0]     n_fts;
        rate_id_e       rate_id;
        training_ctrl_t train_ctl;
    } pcie_tsos_cfg_t;

endpackage

// File: rtl/pcie_tsos_lane_fmt.sv
// rtl/pcie_tsos_lane_fmt.sv - builds the 16 symbols and K flags of one lane's TS ordered set
module pcie_tsos_lane_fmt
    import pcie_phy_pkg::*;
#(
    parameter int NUM_LANES = 4
) (
    input  pcie_tsos_cfg_t               cfg,
    input  logic [7:0]                   lane_idx,
    output logic [TSOS_SYMS*8-1:0]       syms,
    output logic [TSOS_SYMS-1:0]         k
);

    logic [7:0] lane_num;

    always_comb begin
        lane_num = cfg.lane_rev ? (8'(NUM_LANES - 1) - lane_idx) : lane_idx;
        k        = '0;
        for (int s = 0; s < TSOS_SYMS; s++) begin
            syms[s*8 +: 8] = cfg.ts_type;
        end
        syms[0*8 +: 8] = K28_5_COM;
        k[0]           = 1'b1;
        syms[1*8 +: 8] = cfg.link_pad ? K23_7_PAD : cfg.link_num;
        k[1]           = cfg.link_pad;
        syms[2*8 +: 8] = cfg.lane_pad ? K23_7_PAD : lane_num;
        k[2]           = cfg.lane_pad;
        syms[3*8 +: 8] = cfg.n_fts;
        syms[4*8 +: 8] = cfg.rate_id;
        syms[5*8 +: 8] = cfg.train_ctl;
    end

endmodule

// File: rtl/pcie_tsos_gen.sv
// rtl/pcie_tsos_gen.sv - TS1/TS2 ordered-set burst generator with a streaming output
module pcie_tsos_gen
    import pcie_phy_pkg::*;
#(
    parameter int NUM_LANES     = 4,
    parameter int SYMS_PER_BEAT = 4,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 start_i,
    input  logic                                 stop_i,
    input  logic [7:0]                           ts_type_i,
    input  logic [7:0]                           link_num_i,
    input  logic                                 link_pad_i,
    input  logic                                 lane_pad_i,
    input  logic                                 lane_rev_i,
    input  logic [7:0]                           n_fts_i,
    input  logic [7:0]                           rate_id_i,
    input  logic [7:0]                           train_ctl_i,
    input  logic [CNT_WIDTH-1:0]                 count_i,
    output logic [NUM_LANES*SYMS_PER_BEAT*8-1:0] m_axis_tdata,
    output logic [NUM_LANES*SYMS_PER_BEAT-1:0]   m_axis_tk,
    output logic                                 m_axis_tvalid,
    input  logic                                 m_axis_tready,
    output logic                                 m_axis_tlast,
    output logic                                 busy_o,
    output logic                                 done_o,
    output logic [CNT_WIDTH-1:0]                 sets_sent_o
);

    localparam int BEATS  = TSOS_SYMS / SYMS_PER_BEAT;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LANE_W = SYMS_PER_BEAT * 8;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, SEND, FINISH} state_e;

    state_e               state_q, state_d;
    pcie_tsos_cfg_t       cfg_q, cfg_in;
    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] sets_q, sets_inc;
    logic [BEAT_W-1:0]    beat_q;
    logic                 stop_q;
    logic                 fire, last_beat, end_burst;

    always_comb begin
        cfg_in.ts_type   = train_seq_e'(ts_type_i);
        cfg_in.link_num  = link_num_i;
        cfg_in.link_pad  = link_pad_i;
        cfg_in.lane_pad  = lane_pad_i;
        cfg_in.lane_rev  = lane_rev_i;
        cfg_in.n_fts     = n_fts_i;
        cfg_in.rate_id   = rate_id_e'(rate_id_i);
        cfg_in.train_ctl = training_ctrl_t'(train_ctl_i);
    end

    assign fire      = (state_q == SEND) && m_axis_tready;
    assign last_beat = (beat_q == LAST_BEAT);
    assign sets_inc  = (&sets_q) ? sets_q : sets_q + 1'b1;
    // A stop seen on the tlast handshake itself still makes this set the final one
    assign end_burst = fire && last_beat &&
                       (((count_q != '0) && (sets_inc == count_q)) || stop_q || stop_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        m_axis_tvalid = 1'b0;
        done_o        = 1'b0;
        busy_o        = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (start_i) state_d = SEND;
            end
            SEND: begin
                m_axis_tvalid = 1'b1;
                if (end_burst) state_d = FINISH;
            end
            FINISH: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cfg_q   <= '0;
            count_q <= '0;
            sets_q  <= '0;
            beat_q  <= '0;
            stop_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        cfg_q   <= cfg_in;
                        count_q <= count_i;
                        sets_q  <= '0;
                        beat_q  <= '0;
                        stop_q  <= 1'b0;
                    end
                end
                SEND: begin
                    if (stop_i) stop_q <= 1'b1;
                    if (fire) begin
                        if (last_beat) begin
                            beat_q <= '0;
                            sets_q <= sets_inc;
                        end else begin
                            beat_q <= beat_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign sets_sent_o  = sets_q;
    assign m_axis_tlast = (state_q == SEND) && last_beat;

    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
        logic [TSOS_SYMS*8-1:0] lane_syms;
        logic [TSOS_SYMS-1:0]   lane_k;

        pcie_tsos_lane_fmt #(
            .NUM_LANES (NUM_LANES)
        ) u_fmt (
            .cfg      (cfg_q),
            .lane_idx (8'(gi)),
            .syms     (lane_syms),
            .k        (lane_k)
        );

        // Outputs are forced to zero outside SEND so idle/reset present a quiet bus
        assign m_axis_tdata[gi*LANE_W +: LANE_W] = (state_q == SEND) ?
            lane_syms[int'(beat_q)*LANE_W +: LANE_W] : '0;
        assign m_axis_tk[gi*SYMS_PER_BEAT +: SYMS_PER_BEAT] = (state_q == SEND) ?
            lane_k[int'(beat_q)*SYMS_PER_BEAT +: SYMS_PER_BEAT] : '0;
    end

endmodule
